// File: rtl/button_debouncer_pkg.sv
// Shared types and defaults for the push-button debouncer and its synchroniser.
// The FSM state encoding is 2 bits so it fits the LED blinker status register.
package button_debouncer_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_PEND   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_PEND = 2'd3
   } btn_state_t;

   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_STABLE_CYCLES = 4;
   localparam int DEF_LONG_CYCLES   = 16;

   // Counter width that can hold every value 0..max_val without wrapping.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// N-flop synchroniser for one asynchronous bit, with a synchronous reset value.
// Generic enough to reuse on other async inputs such as a UART RX pin.
module bit_synchronizer #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   if (STAGES < 2) begin : g_bad_stages
      $fatal(1, "bit_synchronizer: STAGES must be >= 2");
   end

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_chain <= {STAGES{RESET_VAL}};
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw push-button pin: synchroniser, stability-counter FSM and
// registered level plus single-cycle press / release / long-press strobes.
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "button_debouncer: SYNC_STAGES must be >= 2");
   end
   if (STABLE_CYCLES < 1) begin : g_bad_stable
      $fatal(1, "button_debouncer: STABLE_CYCLES must be >= 1");
   end
   if (LONG_CYCLES <= STABLE_CYCLES) begin : g_bad_long
      $fatal(1, "button_debouncer: LONG_CYCLES must exceed STABLE_CYCLES");
   end

   localparam int STAB_W = cnt_width(STABLE_CYCLES);
   localparam int HOLD_W = cnt_width(LONG_CYCLES);

   localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 2);

   logic w_sync_pin;
   logic w_btn_sync;
   logic w_pend_done;

   btn_state_t        r_state;
   logic [STAB_W-1:0] r_stab_cnt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic              r_btn_level;
   logic              r_press_pulse;
   logic              r_release_pulse;
   logic              r_long_pulse;

   bit_synchronizer #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (ACTIVE_LOW)
   ) u_sync (
      .i_clk   (clk),
      .i_reset (reset),
      .i_d     (btn_raw),
      .o_q     (w_sync_pin)
   );

   assign w_btn_sync = ACTIVE_LOW ? ~w_sync_pin : w_sync_pin;

   // The entry cycle already counts as one stable sample, so >= also covers STABLE_CYCLES=1.
   assign w_pend_done = (r_stab_cnt >= STAB_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= ST_RELEASED;
         r_stab_cnt      <= '0;
         r_hold_cnt      <= '0;
         r_btn_level     <= 1'b0;
         r_press_pulse   <= 1'b0;
         r_release_pulse <= 1'b0;
         r_long_pulse    <= 1'b0;
      end else begin
         r_press_pulse   <= 1'b0;
         r_release_pulse <= 1'b0;
         r_long_pulse    <= 1'b0;

         case (r_state)
            ST_RELEASED: begin
               if (w_btn_sync) begin
                  r_state    <= ST_PRESS_PEND;
                  r_stab_cnt <= STAB_ONE;
               end
            end
            ST_PRESS_PEND: begin
               if (!w_btn_sync) begin
                  r_state    <= ST_RELEASED;
                  r_stab_cnt <= '0;
               end else if (w_pend_done) begin
                  r_state       <= ST_PRESSED;
                  r_stab_cnt    <= '0;
                  r_btn_level   <= 1'b1;
                  r_press_pulse <= 1'b1;
               end else begin
                  r_stab_cnt <= r_stab_cnt + STAB_ONE;
               end
            end
            ST_PRESSED: begin
               if (!w_btn_sync) begin
                  r_state    <= ST_RELEASE_PEND;
                  r_stab_cnt <= STAB_ONE;
               end
            end
            ST_RELEASE_PEND: begin
               if (w_btn_sync) begin
                  r_state    <= ST_PRESSED;
                  r_stab_cnt <= '0;
               end else if (w_pend_done) begin
                  r_state         <= ST_RELEASED;
                  r_stab_cnt      <= '0;
                  r_btn_level     <= 1'b0;
                  r_release_pulse <= 1'b1;
               end else begin
                  r_stab_cnt <= r_stab_cnt + STAB_ONE;
               end
            end
            default: begin
               r_state    <= ST_RELEASED;
               r_stab_cnt <= '0;
            end
         endcase

         // Hold time keeps running through a release bounce; only a committed release clears it.
         if (r_state == ST_PRESSED || r_state == ST_RELEASE_PEND) begin
            if (r_state == ST_RELEASE_PEND && !w_btn_sync && w_pend_done) begin
               r_hold_cnt <= '0;
            end else if (r_hold_cnt != HOLD_MAX) begin
               r_hold_cnt   <= r_hold_cnt + HOLD_ONE;
               r_long_pulse <= (r_hold_cnt == HOLD_PRE) && w_btn_sync;
            end
         end else begin
            r_hold_cnt <= '0;
         end
      end
   end

   assign btn_level     = r_btn_level;
   assign press_pulse   = r_press_pulse;
   assign release_pulse = r_release_pulse;
   assign long_pulse    = r_long_pulse;

   a_strobes_exclusive : assert property (@(posedge clk) disable iff (reset)
      $onehot0({r_press_pulse, r_release_pulse, r_long_pulse}));

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: an active-high and an active-low instance
// driven with complementary pins, checked edge by edge against hand-computed timing.
module tb_button_debouncer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic btn_raw = 1'b1;
   logic btn_raw_n;

   logic hi_level, hi_press, hi_release, hi_long;
   logic lo_level, lo_press, lo_release, lo_long;

   int n_vec = 0;
   int n_err = 0;

   assign btn_raw_n = ~btn_raw;

   always #5 clk = ~clk;

   button_debouncer #(
      .SYNC_STAGES   (2),
      .STABLE_CYCLES (4),
      .LONG_CYCLES   (16),
      .ACTIVE_LOW    (1'b0)
   ) dut_hi (
      .clk           (clk),
      .reset         (reset),
      .btn_raw       (btn_raw),
      .btn_level     (hi_level),
      .press_pulse   (hi_press),
      .release_pulse (hi_release),
      .long_pulse    (hi_long)
   );

   button_debouncer #(
      .SYNC_STAGES   (2),
      .STABLE_CYCLES (4),
      .LONG_CYCLES   (16),
      .ACTIVE_LOW    (1'b1)
   ) dut_lo (
      .clk           (clk),
      .reset         (reset),
      .btn_raw       (btn_raw_n),
      .btn_level     (lo_level),
      .press_pulse   (lo_press),
      .release_pulse (lo_release),
      .long_pulse    (lo_long)
   );

   task automatic check_val(input string tag, input logic obs, input logic exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   // Advance one clock edge, then compare both instances one time unit later.
   task automatic step(input string name, input int k,
                       input logic p, input logic r, input logic l, input logic v);
      string tag;
      @(posedge clk);
      #1;
      tag = $sformatf("%s[%0d]", name, k);
      check_val({tag, ".press"},      hi_press,   p);
      check_val({tag, ".release"},    hi_release, r);
      check_val({tag, ".long"},       hi_long,    l);
      check_val({tag, ".level"},      hi_level,   v);
      check_val({tag, ".al_press"},   lo_press,   p);
      check_val({tag, ".al_release"}, lo_release, r);
      check_val({tag, ".al_long"},    lo_long,    l);
      check_val({tag, ".al_level"},   lo_level,   v);
   endtask

   initial begin
      // Reset held with the pin pressed; nothing may appear after reset releases.
      reset   = 1'b1;
      btn_raw = 1'b1;
      for (int k = 1; k <= 3; k++) step("reset", k, 0, 0, 0, 0);
      reset   = 1'b0;
      btn_raw = 1'b0;
      for (int k = 1; k <= 10; k++) step("post_reset", k, 0, 0, 0, 0);

      // Clean press: pin rises before edge 1, press on edge 6, long press on edge 21.
      btn_raw = 1'b1;
      for (int k = 1; k <= 30; k++) step("clean_press", k, k == 6, 0, k == 21, k >= 6);
      btn_raw = 1'b0;
      for (int k = 1; k <= 10; k++) step("clean_release", k, 0, k == 6, 0, k < 6);

      // Bounce 1,0,1,0 two cycles each: must never commit.
      for (int i = 0; i < 8; i++) begin
         btn_raw = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
         step("bounce", i, 0, 0, 0, 0);
      end

      // Steady press after the bounce, with a 3-cycle release glitch at edges 11..13.
      for (int k = 1; k <= 25; k++) begin
         btn_raw = (k >= 11 && k <= 13) ? 1'b0 : 1'b1;
         step("bounce_hold", k, k == 6, 0, k == 21, k >= 6);
      end
      btn_raw = 1'b0;
      for (int k = 1; k <= 10; k++) step("bounce_release", k, 0, k == 6, 0, k < 6);

      // Reset with the press counter at 2, then a full re-qualification.
      btn_raw = 1'b1;
      for (int k = 1; k <= 4; k++) step("pre_mid_reset", k, 0, 0, 0, 0);
      reset = 1'b1;
      for (int k = 1; k <= 2; k++) step("mid_reset", k, 0, 0, 0, 0);
      reset = 1'b0;
      for (int k = 1; k <= 8; k++) step("repress", k, k == 6, 0, 0, k >= 6);
      btn_raw = 1'b0;
      for (int k = 1; k <= 8; k++) step("final_release", k, 0, k == 6, 0, k < 6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
